// File: rtl/fft_frame_sched_if.sv
// Bundle between the requester sample buffers, the scheduler and the FFT.
// Ports (master = scheduler side):
//   req_i, req_re_i, req_im_i  requester frame-ready flags and FWFT head samples
//   rd_o, gnt_o                per-requester pop strobe and whole-frame grant
//   fft_val_o, fft_re_o/_im_o  sample stream into the FFT
//   fft_val_i                  FFT output valid
//   out_val_o, out_last_o, out_id_o  labels for the FFT output stream
//   busy_o, err_o              activity and sticky orphan-output flag
interface fft_frame_sched_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_WID = 16
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          req_i;
  logic [NUM_REQ*DATA_WID-1:0] req_re_i;
  logic [NUM_REQ*DATA_WID-1:0] req_im_i;
  logic [NUM_REQ-1:0]          rd_o;
  logic [NUM_REQ-1:0]          gnt_o;
  logic                        fft_val_o;
  logic [DATA_WID-1:0]         fft_re_o;
  logic [DATA_WID-1:0]         fft_im_o;
  logic                        fft_val_i;
  logic                        out_val_o;
  logic                        out_last_o;
  logic [ID_W-1:0]             out_id_o;
  logic                        busy_o;
  logic                        err_o;

  modport master (
    input  req_i, req_re_i, req_im_i, fft_val_i,
    output rd_o, gnt_o, fft_val_o, fft_re_o, fft_im_o,
           out_val_o, out_last_o, out_id_o, busy_o, err_o
  );

  modport slave (
    output req_i, req_re_i, req_im_i, fft_val_i,
    input  rd_o, gnt_o, fft_val_o, fft_re_o, fft_im_o,
           out_val_o, out_last_o, out_id_o, busy_o, err_o
  );
endinterface

// File: rtl/fft_frame_sched.sv
// Shares one serial FFT among NUM_REQ requesters: grants whole frames
// round-robin, streams FFT_LEN contiguous samples per frame, records the
// requester ID of each issued frame in a tag FIFO and labels the FFT output
// frames with those IDs.
// Ports: clk, rst_n (async, active-low); bus (fft_frame_sched_if.master).
//   rd_o and out_val_o/out_last_o/out_id_o are combinational, busy_o is
//   decoded from registers, all other outputs are registered.
module fft_frame_sched #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned FFT_LEN   = 64,
  parameter int unsigned DATA_WID  = 16,
  parameter int unsigned TAG_DEPTH = 4,
  parameter int unsigned GAP       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  fft_frame_sched_if.master bus
);
  localparam int unsigned ID_W   = $clog2(NUM_REQ);
  localparam int unsigned CNT_W  = $clog2(FFT_LEN);
  localparam int unsigned PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned TCNT_W = PTR_W + 1;
  localparam int unsigned GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_GAP} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     sel_q, sel_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                fft_val_q;
  logic [DATA_WID-1:0] fft_re_q, fft_im_q;
  logic [ID_W-1:0]     tag_mem_q [TAG_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [TCNT_W-1:0]   tag_cnt_q;
  logic [CNT_W-1:0]    out_cnt_q;
  logic                mask_q;
  logic                err_q;

  logic                pick_vld_c;
  logic [ID_W-1:0]     pick_id_c;
  logic                push_c, pop_c;
  logic                tag_full_c, tag_empty_c;
  logic                act_c, out_val_c, last_cnt_c;

  // First requesting index at or after rr_ptr, cyclically (lowest offset wins).
  always_comb begin
    int unsigned     idx;
    logic [ID_W-1:0] cand;
    idx        = 0;
    cand       = '0;
    pick_vld_c = 1'b0;
    pick_id_c  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx  = (32'(rr_ptr_q) + 32'(i)) % NUM_REQ;
      cand = ID_W'(idx);
      if (bus.req_i[cand]) begin
        pick_vld_c = 1'b1;
        pick_id_c  = cand;
      end
    end
  end

  assign tag_full_c  = (tag_cnt_q == TCNT_W'(TAG_DEPTH));
  assign tag_empty_c = (tag_cnt_q == '0);

  // Output labelling: only the first FFT_LEN valid cycles of a burst count.
  assign act_c      = bus.fft_val_i & ~mask_q;
  assign out_val_c  = act_c & ~tag_empty_c;
  assign last_cnt_c = (out_cnt_q == CNT_W'(FFT_LEN - 1));
  assign pop_c      = out_val_c & last_cnt_c;

  // Frame FSM: next state, grant, pointers and counters.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    in_cnt_d  = in_cnt_q;
    gap_cnt_d = gap_cnt_q;
    push_c    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld_c && !tag_full_c) begin
          state_d  = ST_STREAM;
          sel_d    = pick_id_c;
          gnt_d    = NUM_REQ'(1) << pick_id_c;
          push_c   = 1'b1;
          rr_ptr_d = (pick_id_c == ID_W'(NUM_REQ - 1)) ? '0 : pick_id_c + ID_W'(1);
          in_cnt_d = '0;
        end
      end
      ST_STREAM: begin
        in_cnt_d = in_cnt_q + CNT_W'(1);
        if (in_cnt_q == CNT_W'(FFT_LEN - 1)) begin
          state_d   = ST_GAP;
          gnt_d     = '0;
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (gap_cnt_q == GAP_W'(GAP - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, input data path, tag FIFO control and output labelling state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      in_cnt_q  <= '0;
      gap_cnt_q <= '0;
      fft_val_q <= 1'b0;
      fft_re_q  <= '0;
      fft_im_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_cnt_q <= '0;
      out_cnt_q <= '0;
      mask_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      in_cnt_q  <= in_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      fft_val_q <= (state_q == ST_STREAM);
      if (state_q == ST_STREAM) begin
        fft_re_q <= bus.req_re_i[sel_q*DATA_WID +: DATA_WID];
        fft_im_q <= bus.req_im_i[sel_q*DATA_WID +: DATA_WID];
      end
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_c && !pop_c)      tag_cnt_q <= tag_cnt_q + TCNT_W'(1);
      else if (!push_c && pop_c) tag_cnt_q <= tag_cnt_q - TCNT_W'(1);
      // Burst end re-arms labelling; the trailing FFT valid cycle is masked.
      if (!bus.fft_val_i) begin
        out_cnt_q <= '0;
        mask_q    <= 1'b0;
      end else if (!mask_q) begin
        if (last_cnt_c) begin
          out_cnt_q <= '0;
          mask_q    <= 1'b1;
        end else begin
          out_cnt_q <= out_cnt_q + CNT_W'(1);
        end
      end
      if (act_c && tag_empty_c) err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read behind the count.
  always_ff @(posedge clk) begin
    if (push_c) tag_mem_q[wr_ptr_q] <= pick_id_c;
  end

  assign bus.gnt_o      = gnt_q;
  assign bus.rd_o       = (state_q == ST_STREAM) ? gnt_q : '0;
  assign bus.fft_val_o  = fft_val_q;
  assign bus.fft_re_o   = fft_re_q;
  assign bus.fft_im_o   = fft_im_q;
  assign bus.out_val_o  = out_val_c;
  assign bus.out_last_o = pop_c;
  assign bus.out_id_o   = out_val_c ? tag_mem_q[rd_ptr_q] : '0;
  assign bus.busy_o     = (state_q != ST_IDLE) | ~tag_empty_c;
  assign bus.err_o      = err_q;
endmodule

// File: doc/fft_frame_sched.md
# fft_frame_sched

Frame scheduler that shares one serial-in/serial-out 64-point FFT datapath among `NUM_REQ` requesters. It grants whole frames round-robin and streams each granted frame into the FFT as `FFT_LEN` contiguous valid samples. It records the requester ID of every issued frame in a tag FIFO and labels the FFT output frames with those IDs. It sits between the sample buffers of the requesters and the FFT top.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `FFT_LEN`, 64: samples per frame (`` `FFT_LEN ``).
- `DATA_WID`, 16: sample width (`` `DATA_WID ``).
- `TAG_DEPTH`, 4: maximum number of frames in flight (power of 2).
- `GAP`, 1: minimum idle cycles between input frames (≥1).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_i`  in  `NUM_REQ`  requester n holds a complete frame; must stay high until its last `rd_o` pulse.
- `req_re_i`, `req_im_i`  in  `NUM_REQ*DATA_WID`  head sample of each requester (first-word-fall-through); slice n is requester n.
- `rd_o`  out  `NUM_REQ`  pop strobe, one-hot, one pulse per consumed sample.
- `gnt_o`  out  `NUM_REQ`  one-hot, high for the whole streamed frame.
- `fft_val_o`  out  1  valid into the FFT.
- `fft_re_o`, `fft_im_o`  out  `DATA_WID`  sample into the FFT.
- `fft_val_i`  in  1  FFT output valid.
- `out_val_o`  out  1  labelled output sample valid.
- `out_last_o`  out  1  last sample of an output frame.
- `out_id_o`  out  `$clog2(NUM_REQ)`  requester ID of the current output frame.
- `busy_o`  out  1  at least one frame in flight, or the FSM is not in IDLE.
- `err_o`  out  1  sticky: FFT output arrived while the tag FIFO was empty.

## Operation
- FSM states: IDLE, STREAM, GAP.
- IDLE → STREAM when `|req_i` is high and the tag FIFO is not full. The scheduler picks the first requester at or after `rr_ptr`, cyclically. In the same edge it:
  - registers `gnt_o`,
  - pushes the requester ID into the tag FIFO,
  - sets `rr_ptr` to ID+1 (wrapping to 0 after `NUM_REQ`-1),
  - clears `in_cnt`.
- STREAM: `rd_o[sel] = 1` combinationally on every cycle. `in_cnt` increments each cycle. When `in_cnt == FFT_LEN-1` the FSM goes to GAP and `gnt_o` clears.
- `req_i` is ignored in STREAM. A requester that drops its request mid-frame does not shorten the frame.
- GAP: lasts `GAP` cycles, then the FSM returns to IDLE. Requests are not sampled during GAP, so `fft_val_o` is low for at least `GAP`+1 cycles between frames. This lets the FFT input counter realign.
- Input data path, registered:
  - `fft_val_o <= (state==STREAM)`.
  - `fft_re_o` / `fft_im_o` take slice `sel` of `req_re_i` / `req_im_i`.
  - Data holds its last value when not valid.
- Output labelling:
  - `out_cnt` counts `fft_val_i` cycles.
  - On count 0..`FFT_LEN`-1 (unmasked): `out_val_o = 1` and `out_id_o` = tag FIFO head.
  - On count `FFT_LEN`-1: `out_last_o = 1`, the tag is popped and the mask is set.
  - While masked, further `fft_val_i` cycles are ignored; the trailing valid cycle the FFT emits is dropped.
  - The mask and `out_cnt` clear on the first cycle with `fft_val_i` low.
  - The output signals are combinational from `fft_val_i`, `out_cnt`, the mask and the FIFO head; the FFT data bus passes by externally.
- Tag FIFO:
  - Push and pop in the same cycle are allowed; the count is unchanged.
  - Full: `count == TAG_DEPTH`. No grant is issued; requests wait.
  - Empty with unmasked `fft_val_i`: `err_o` sets, `out_val_o` = 0, `out_cnt` still advances.
- `busy_o = (state != IDLE) | (tag count != 0)`.

## Timing
- Reset values: FSM IDLE, `rr_ptr` 0, counters 0, tag FIFO empty, mask 0. All of these outputs reset to 0: `gnt_o`, `rd_o`, `fft_val_o`, `fft_re_o`, `fft_im_o`, `out_val_o`, `out_last_o`, `out_id_o`, `err_o`, `busy_o`.
- Request at edge T (IDLE, FIFO not full):
  - `gnt_o` and `rd_o` go high in cycle T+1 and stay high through T+`FFT_LEN`.
  - `fft_val_o` is high in cycles T+2 .. T+`FFT_LEN`+1.
- Back-to-back requests: the next grant edge is T+`FFT_LEN`+`GAP`+1, so the period is 66 cycles for `GAP`=1.
- The `rd_o` sample k and the `fft_val_o` sample k are one cycle apart.
- Reset mid-frame: everything returns to reset values immediately; the partial frame is abandoned and tags in flight are lost.

## Test plan
- Single frame: `req_i`=4'b0100, ramp data 0..63 → `gnt_o`[2] high for 64 cycles, 64 `rd_o` pulses, `fft_val_o` carries 0..63 starting 1 cycle after `rd_o`. Output frame: 64 `out_val_o` with `out_id_o`=2, `out_last_o` on the 64th, a 65th `fft_val_i` cycle dropped.
- Round-robin: `req_i`=4'b1111 held → grant order 0,1,2,3,0, grant starts 66 cycles apart, `fft_val_o` low for ≥2 cycles between frames.
- Back-pressure: `TAG_DEPTH`=4, no FFT output, 6 requests → exactly 4 grants, then none; after one output frame completes, the 5th grant follows within 2 cycles.
- Simultaneous push/pop: a grant edge coincides with `out_last_o` → tag count unchanged and IDs remain in order.
- Spurious output: `fft_val_i` pulsed with the FIFO empty → `err_o`=1 and sticky, `out_val_o`=0.
- Reset mid-STREAM at sample 30 → the next cycle shows all outputs 0; a fresh request afterwards streams a full 64-sample frame labelled with the correct ID.
